// File: rtl/pc_bank.sv
// Per-thread program counter, NZP flags and hardware return stack
// for every thread of a core, plus the warp convergence flag.
package gpu_pkg;
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FETCH   = 3'd1,
        DECODE  = 3'd2,
        REQUEST = 3'd3,
        WAIT    = 3'd4,
        EXECUTE = 3'd5,
        UPDATE  = 3'd6,
        DONE    = 3'd7
    } core_state_t;
endpackage

module pc_bank
    import gpu_pkg::*;
#(
    parameter int THREADS     = 4,
    parameter int ADDR_WIDTH  = 8,
    parameter int DATA_WIDTH  = 8,
    parameter int STACK_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [THREADS-1:0]            thread_enable,
    input  core_state_t                   core_state,
    input  logic [2:0]                    pc_op,
    input  logic                          nzp_write_enable,
    input  logic [2:0]                    branch_condition,
    input  logic [THREADS*DATA_WIDTH-1:0] alu_result,
    input  logic [ADDR_WIDTH-1:0]         branch_target,
    input  logic [ADDR_WIDTH-1:0]         current_pc,
    output logic [THREADS*ADDR_WIDTH-1:0] next_pc,
    output logic [THREADS*3-1:0]          nzp,
    output logic [THREADS-1:0]            stack_overflow,
    output logic [THREADS-1:0]            stack_underflow,
    output logic                          converged
);

    localparam int SPW = $clog2(STACK_DEPTH + 1);
    localparam int IW  = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [SPW-1:0] DEPTH = SPW'(STACK_DEPTH);

    localparam logic [2:0] OP_BRANCH = 3'd1;
    localparam logic [2:0] OP_JUMP   = 3'd2;
    localparam logic [2:0] OP_CALL   = 3'd3;
    localparam logic [2:0] OP_RET    = 3'd4;

    logic [ADDR_WIDTH-1:0] pc_inc;
    logic [ADDR_WIDTH-1:0] pc_q [THREADS];

    assign pc_inc = current_pc + ADDR_WIDTH'(1);

    for (genvar t = 0; t < THREADS; t++) begin : g_thr
        logic [2:0]            nzp_q;
        logic [SPW-1:0]        sp_q;
        logic [ADDR_WIDTH-1:0] stack_q [STACK_DEPTH];
        logic                  ovf_q;
        logic                  udf_q;
        logic [IW-1:0]         push_idx;
        logic [IW-1:0]         pop_idx;
        logic                  take;

        assign push_idx = IW'(sp_q);
        assign pop_idx  = IW'(sp_q - SPW'(1));
        assign take     = |(nzp_q & branch_condition);

        always_ff @(posedge clk) begin
            if (rst) begin
                pc_q[t] <= '0;
                nzp_q   <= '0;
                sp_q    <= '0;
                ovf_q   <= 1'b0;
                udf_q   <= 1'b0;
                for (int k = 0; k < STACK_DEPTH; k++) begin
                    stack_q[k] <= '0;
                end
            end else if (thread_enable[t]) begin
                if (core_state == EXECUTE) begin
                    case (pc_op)
                        OP_BRANCH: pc_q[t] <= take ? branch_target : pc_inc;
                        OP_JUMP:   pc_q[t] <= branch_target;
                        OP_CALL: begin
                            pc_q[t] <= branch_target;
                            if (sp_q < DEPTH) begin
                                stack_q[push_idx] <= pc_inc;
                                sp_q <= sp_q + SPW'(1);
                            end else begin
                                ovf_q <= 1'b1;
                            end
                        end
                        OP_RET: begin
                            if (sp_q != '0) begin
                                pc_q[t] <= stack_q[pop_idx];
                                sp_q <= sp_q - SPW'(1);
                            end else begin
                                pc_q[t] <= pc_inc;
                                udf_q <= 1'b1;
                            end
                        end
                        default:   pc_q[t] <= pc_inc;
                    endcase
                end else if (core_state == UPDATE && nzp_write_enable) begin
                    nzp_q <= alu_result[t*DATA_WIDTH +: 3];
                end
            end
        end

        assign next_pc[t*ADDR_WIDTH +: ADDR_WIDTH] = pc_q[t];
        assign nzp[t*3 +: 3]      = nzp_q;
        assign stack_overflow[t]  = ovf_q;
        assign stack_underflow[t] = udf_q;
    end

    // Compare every enabled thread against the first enabled one.
    always_comb begin
        logic                  seen;
        logic [ADDR_WIDTH-1:0] ref_pc;
        converged = 1'b1;
        seen      = 1'b0;
        ref_pc    = '0;
        for (int t = 0; t < THREADS; t++) begin
            if (thread_enable[t]) begin
                if (!seen) begin
                    seen   = 1'b1;
                    ref_pc = pc_q[t];
                end else if (pc_q[t] != ref_pc) begin
                    converged = 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_pc_bank.sv
// Directed bench for pc_bank with a queue-based reference model
// checked every cycle plus literal expectations.
module tb_pc_bank;
    import gpu_pkg::*;

    localparam int T  = 4;
    localparam int AW = 8;
    localparam int DW = 8;
    localparam int SD = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [T-1:0]     thread_enable;
    core_state_t      core_state;
    logic [2:0]       pc_op;
    logic             nzp_write_enable;
    logic [2:0]       branch_condition;
    logic [T*DW-1:0]  alu_result;
    logic [AW-1:0]    branch_target;
    logic [AW-1:0]    current_pc;
    logic [T*AW-1:0]  next_pc;
    logic [T*3-1:0]   nzp;
    logic [T-1:0]     stack_overflow;
    logic [T-1:0]     stack_underflow;
    logic             converged;

    int total = 0;
    int bad   = 0;

    pc_bank #(
        .THREADS(T), .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW), .STACK_DEPTH(SD)
    ) dut (
        .clk(clk), .rst(rst),
        .thread_enable(thread_enable),
        .core_state(core_state),
        .pc_op(pc_op),
        .nzp_write_enable(nzp_write_enable),
        .branch_condition(branch_condition),
        .alu_result(alu_result),
        .branch_target(branch_target),
        .current_pc(current_pc),
        .next_pc(next_pc),
        .nzp(nzp),
        .stack_overflow(stack_overflow),
        .stack_underflow(stack_underflow),
        .converged(converged)
    );

    always #5 clk = ~clk;

    // Reference model: plain arrays and a queue per thread as the stack.
    logic [AW-1:0] m_pc  [T];
    logic [2:0]    m_nzp [T];
    logic [AW-1:0] m_stk [T][$];
    logic [T-1:0]  m_ovf;
    logic [T-1:0]  m_udf;
    bit            started = 0;

    function automatic logic m_conv();
        logic [AW-1:0] first;
        bit have;
        have  = 0;
        first = '0;
        for (int i = 0; i < T; i++) begin
            if (thread_enable[i]) begin
                if (!have) begin
                    have  = 1;
                    first = m_pc[i];
                end else if (m_pc[i] != first) begin
                    return 1'b0;
                end
            end
        end
        return 1'b1;
    endfunction

    always @(posedge clk) begin
        logic [AW-1:0] inc;
        inc = current_pc + 8'd1;
        started = 1;
        if (rst) begin
            for (int i = 0; i < T; i++) begin
                m_pc[i]  = '0;
                m_nzp[i] = '0;
                m_stk[i].delete();
            end
            m_ovf = '0;
            m_udf = '0;
        end else begin
            for (int i = 0; i < T; i++) begin
                if (!thread_enable[i]) continue;
                if (core_state == EXECUTE) begin
                    if (pc_op == 3'd1) begin
                        if ((m_nzp[i] & branch_condition) != 0)
                            m_pc[i] = branch_target;
                        else
                            m_pc[i] = inc;
                    end else if (pc_op == 3'd2) begin
                        m_pc[i] = branch_target;
                    end else if (pc_op == 3'd3) begin
                        if (m_stk[i].size() < SD)
                            m_stk[i].push_back(inc);
                        else
                            m_ovf[i] = 1'b1;
                        m_pc[i] = branch_target;
                    end else if (pc_op == 3'd4) begin
                        if (m_stk[i].size() > 0) begin
                            m_pc[i] = m_stk[i].pop_back();
                        end else begin
                            m_udf[i] = 1'b1;
                            m_pc[i]  = inc;
                        end
                    end else begin
                        m_pc[i] = inc;
                    end
                end else if (core_state == UPDATE && nzp_write_enable) begin
                    m_nzp[i] = alu_result[i*DW +: 3];
                end
            end
        end
    end

    task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h at %0t", name, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (started) begin
            for (int i = 0; i < T; i++) begin
                chk($sformatf("pc%0d", i), 32'(next_pc[i*AW +: AW]), 32'(m_pc[i]));
                chk($sformatf("nzp%0d", i), 32'(nzp[i*3 +: 3]), 32'(m_nzp[i]));
            end
            chk("ovf", 32'(stack_overflow), 32'(m_ovf));
            chk("udf", 32'(stack_underflow), 32'(m_udf));
            chk("conv", 32'(converged), 32'(m_conv()));
        end
    end

    // Apply one operation for a single edge, then return to IDLE.
    task automatic op(core_state_t cs, logic [2:0] o,
                      logic [AW-1:0] cur, logic [AW-1:0] tgt);
        core_state    = cs;
        pc_op         = o;
        current_pc    = cur;
        branch_target = tgt;
        @(posedge clk);
        #2;
        core_state = IDLE;
    endtask

    task automatic lit_pcs(string name, logic [T*AW-1:0] exp);
        chk({name, "_dut"}, next_pc, exp);
        chk({name, "_mdl"}, {m_pc[3], m_pc[2], m_pc[1], m_pc[0]}, exp);
    endtask

    initial begin
        rst              = 1'b1;
        thread_enable    = 4'($urandom);
        core_state       = core_state_t'($urandom_range(0, 7));
        pc_op            = 3'($urandom);
        nzp_write_enable = 1'b1;
        branch_condition = 3'($urandom);
        alu_result       = $urandom;
        branch_target    = 8'($urandom);
        current_pc       = 8'($urandom);
        @(posedge clk);
        #2;
        core_state = core_state_t'(3'd5);
        @(posedge clk);
        #2;
        rst              = 1'b0;
        core_state       = IDLE;
        thread_enable    = 4'hF;
        nzp_write_enable = 1'b0;
        lit_pcs("rst_pc", 32'h0);
        chk("rst_conv", 32'(converged), 32'd1);
        chk("rst_flags", 32'({stack_overflow, stack_underflow, nzp}), 32'd0);

        // Wrap of the sequential increment
        op(EXECUTE, 3'd2, 8'h00, 8'h33);
        op(EXECUTE, 3'd0, 8'hFF, 8'h00);
        lit_pcs("seq_wrap", 32'h00000000);

        // Divergent branch on per-thread NZP
        nzp_write_enable = 1'b1;
        alu_result = {8'h02, 8'h01, 8'h02, 8'h04};
        op(UPDATE, 3'd0, 8'h00, 8'h00);
        nzp_write_enable = 1'b0;
        chk("nzp_load", 32'(nzp), 32'b010_001_010_100);
        branch_condition = 3'b010;
        op(EXECUTE, 3'd1, 8'h10, 8'h40);
        lit_pcs("branch", 32'h40114011);
        chk("div_conv", 32'(converged), 32'd0);
        thread_enable = 4'b1010;
        #1;
        chk("sub_conv", 32'(converged), 32'd1);
        thread_enable = 4'hF;

        // Nested call and return
        op(EXECUTE, 3'd3, 8'h05, 8'h20);
        lit_pcs("call1", 32'h20202020);
        op(EXECUTE, 3'd3, 8'h21, 8'h30);
        lit_pcs("call2", 32'h30303030);
        op(EXECUTE, 3'd4, 8'h30, 8'h00);
        lit_pcs("ret1", 32'h22222222);
        op(EXECUTE, 3'd4, 8'h22, 8'h00);
        lit_pcs("ret2", 32'h06060606);
        chk("nest_flags", 32'({stack_overflow, stack_underflow}), 32'd0);

        // Overflow then underflow
        for (int k = 0; k < 5; k++)
            op(EXECUTE, 3'd3, 8'(8'h50 + k), 8'(8'h60 + k));
        lit_pcs("ovf_pc", 32'h64646464);
        chk("ovf_set", 32'(stack_overflow), 32'hF);
        for (int k = 0; k < 4; k++) begin
            op(EXECUTE, 3'd4, 8'h70, 8'h00);
            chk($sformatf("pop%0d", k), 32'(next_pc[7:0]), 32'(8'h54 - k));
        end
        chk("udf_clear", 32'(stack_underflow), 32'd0);
        op(EXECUTE, 3'd4, 8'h70, 8'h00);
        lit_pcs("udf_pc", 32'h71717171);
        chk("udf_set", 32'(stack_underflow), 32'hF);
        repeat (3) @(posedge clk);
        #2;
        chk("flags_hold", 32'({stack_overflow, stack_underflow}), 32'hFF);

        // Enable masking
        thread_enable = 4'b0101;
        op(EXECUTE, 3'd2, 8'h00, 8'h07);
        nzp_write_enable = 1'b1;
        alu_result = {8'h07, 8'h07, 8'h07, 8'h07};
        op(UPDATE, 3'd0, 8'h00, 8'h00);
        nzp_write_enable = 1'b0;
        lit_pcs("mask_pc", 32'h71077107);
        chk("mask_nzp", 32'(nzp), 32'b010_111_010_111);

        // Reset clears sticky flags
        rst = 1'b1;
        @(posedge clk);
        #2;
        rst = 1'b0;
        chk("rst2_flags", 32'({stack_overflow, stack_underflow}), 32'd0);
        lit_pcs("rst2_pc", 32'h0);
        @(posedge clk);
        #2;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pc_bank.md
# pc_bank

Per-core bank of THREADS program-counter/NZP units with a per-thread hardware call stack; a parametrised successor to the single-thread PC. Each enabled thread computes its own next PC in EXECUTE (sequential, conditional branch, jump, call, return) and latches its NZP flags in UPDATE. The scheduler reads the per-thread `next_pc` vector and the `converged` flag to decide whether the warp can continue from a single PC.

## Interface
Parameters:
- THREADS, 4: threads per core (≥1)
- ADDR_WIDTH, 8: program memory address width
- DATA_WIDTH, 8: ALU result width per thread (≥3)
- STACK_DEPTH, 4: return-address entries per thread (≥1)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- thread_enable  in  THREADS  bit i gates all state updates of thread i
- core_state  in  core_state_t  core state from gpu_pkg; only EXECUTE and UPDATE act
- pc_op  in  3  0 SEQ, 1 BRANCH, 2 JUMP, 3 CALL, 4 RET, 5–7 treated as SEQ
- nzp_write_enable  in  1  latch NZP in UPDATE
- branch_condition  in  3  NZP mask {N,Z,P} for BRANCH
- alu_result  in  THREADS*DATA_WIDTH  thread i at [i*DATA_WIDTH +: DATA_WIDTH]; NZP in bits [2:0]
- branch_target  in  ADDR_WIDTH  target for BRANCH/JUMP/CALL (shared)
- current_pc  in  ADDR_WIDTH  warp PC of the executing instruction
- next_pc  out  THREADS*ADDR_WIDTH  registered per-thread next PC, thread i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- nzp  out  THREADS*3  registered per-thread NZP
- stack_overflow  out  THREADS  sticky: CALL issued with stack full
- stack_underflow  out  THREADS  sticky: RET issued with stack empty
- converged  out  1  all enabled threads hold identical next_pc

## Operation
- Per thread i: registers next_pc_i, nzp_i, sp_i (width clog2(STACK_DEPTH+1)), stack_i[STACK_DEPTH], ovf_i, udf_i.
- Thread updates only when thread_enable[i]=1; disabled threads hold all state.
- EXECUTE, by pc_op (inc = current_pc+1, modulo 2^ADDR_WIDTH; 2^ADDR_WIDTH−1 wraps to 0):
  - SEQ: next_pc_i ← inc.
  - BRANCH: next_pc_i ← branch_target if (nzp_i & branch_condition)≠0, else inc. Uses NZP held before the edge.
  - JUMP: next_pc_i ← branch_target unconditionally.
  - CALL: if sp_i<STACK_DEPTH: stack_i[sp_i] ← inc, sp_i+1. If full: no push, sp unchanged, ovf_i ← 1. In both cases next_pc_i ← branch_target.
  - RET: if sp_i>0: next_pc_i ← stack_i[sp_i−1], sp_i−1. If empty: udf_i ← 1, next_pc_i ← inc.
- UPDATE with nzp_write_enable=1: nzp_i ← alu_result_i[2:0]. The value is not decoded or checked.
- All other core_state values: no state change.
- EXECUTE and UPDATE are mutually exclusive, so a branch and an NZP write never coincide.
- converged = 1 if no thread enabled, else AND over enabled pairs of next_pc equality. Combinational from registers and thread_enable.
- ovf_i/udf_i clear only on rst.

## Timing
- On the rst edge: next_pc, nzp, sp, stack entries, and both flag vectors are all cleared to 0. converged therefore reads 1 after reset.
- rst overrides core_state/enables in the same cycle. Reset mid-call discards stack contents.
- Latency: next_pc/nzp/sp/flags are visible 1 cycle after the EXECUTE/UPDATE edge. converged follows next_pc with zero added latency.
- Back-to-back EXECUTE cycles are legal. Each uses the sp left by the previous one, so CALL then RET returns inc of the CALL.
- No handshake. The caller holds inputs stable for the sampling edge only.

## Test plan
- Reset: assert rst 1 cycle with random inputs → all next_pc=0, nzp=0, flags=0, converged=1.
- SEQ/wrap: ADDR_WIDTH=8, current_pc=8'hFF, SEQ, all enabled → every next_pc=8'h00.
- Divergent branch: UPDATE with alu_result nzp {100,010,001,010}, then EXECUTE BRANCH cond=010, target=0x40, current_pc=0x10 → next_pc {0x11,0x40,0x11,0x40}, converged=0. Disable threads 0/2 → converged=1.
- Call/return nest: STACK_DEPTH=4; CALL at pc 0x05→0x20, CALL at 0x21→0x30, RET, RET → next_pc 0x20, 0x30, 0x22, 0x06; no flags.
- Overflow/underflow: 5 CALLs → stack_overflow=1 after 5th with next_pc=target; 5 RETs → first 4 pop correctly, 5th sets stack_underflow=1 with next_pc=current_pc+1. Flags persist until rst.
- Enable masking: thread_enable=4'b0101 during JUMP 0x7 and UPDATE → only threads 0,2 change; threads 1,3 retain prior next_pc/nzp.
